// File: rtl/unified_buffer_v2.sv
// unified_buffer_v2
//   Unified buffer between the accumulators and the input setup stage.
//   Stores land NUM_CH*CH_WORDS words at once, either at an explicit address
//   or at an internal auto-increment pointer. Reads stream rd_len beats of
//   RD_WORDS words each over a valid/ready handshake. Out-of-range stores and
//   read requests raise a sticky err_oob flag.
//
//   Optional build macro: UB_ACT_PRELOAD_EN
//     When defined, reset loads activations 11, 12, 21, 22 at
//     PRELOAD_BASE..PRELOAD_BASE+3. All other words reset to 0.
//
// Ports
//   clk, reset               clock (rising), asynchronous active-low reset
//   wr_valid/wr_ready        store handshake (always ready out of reset)
//   wr_auto, wr_addr         address select: auto pointer or explicit base
//   wr_data                  W words, word k at slice k*DATA_WIDTH
//   wr_ptr                   next auto-store address
//   rd_req, rd_addr, rd_len  read request pulse, base address, beat count
//   rd_busy                  read stream in progress
//   rd_valid/rd_ready        beat handshake
//   rd_data, rd_last         beat payload (word i at slice i*DATA_WIDTH), final beat
//   err_oob, err_clr         sticky range error and its clear
module unified_buffer_v2 #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 64,
  parameter int ADDR_WIDTH   = 6,
  parameter int NUM_CH       = 2,
  parameter int CH_WORDS     = 2,
  parameter int RD_WORDS     = 4,
  parameter int LEN_WIDTH    = 4,
  parameter int PRELOAD_BASE = 30
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    wr_valid,
  output logic                                    wr_ready,
  input  logic                                    wr_auto,
  input  logic [ADDR_WIDTH-1:0]                   wr_addr,
  input  logic [NUM_CH*CH_WORDS*DATA_WIDTH-1:0]   wr_data,
  output logic [ADDR_WIDTH-1:0]                   wr_ptr,
  input  logic                                    rd_req,
  input  logic [ADDR_WIDTH-1:0]                   rd_addr,
  input  logic [LEN_WIDTH-1:0]                    rd_len,
  output logic                                    rd_busy,
  output logic                                    rd_valid,
  input  logic                                    rd_ready,
  output logic [RD_WORDS*DATA_WIDTH-1:0]          rd_data,
  output logic                                    rd_last,
  output logic                                    err_oob,
  input  logic                                    err_clr
);

  localparam int W  = NUM_CH * CH_WORDS;
  // Extended width for every address/range computation so that
  // base + span can never overflow before the DEPTH comparison.
  localparam int AW = ADDR_WIDTH + LEN_WIDTH + 1;

  typedef logic [AW-1:0] ext_t;
  typedef enum logic {IDLE, STREAM} state_t;

  // ---------------------------------------------------------------- state
  logic [DATA_WIDTH-1:0]         mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]         mem_d [DEPTH];
  // Pointer is kept one step wider than the port: after filling the last
  // slot it holds DEPTH, so further auto stores flag an error instead of
  // silently wrapping to address 0.
  ext_t                          wr_ptr_q, wr_ptr_d;
  state_t                        state_q, state_d;
  ext_t                          rd_ptr_q, rd_ptr_d;    // address of current beat
  logic [LEN_WIDTH-1:0]          rem_q, rem_d;          // beats left after current
  logic                          rd_valid_q, rd_valid_d;
  logic                          rd_last_q, rd_last_d;
  logic [RD_WORDS*DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                          err_q, err_d;

  // ------------------------------------------------------------ decode
  ext_t wr_base, rd_span, fetch_addr;
  logic wr_oob, wr_do, rd_oob, rd_start, rd_bad, rd_fire, rd_adv, rd_done;

  always_comb begin
    wr_base  = wr_auto ? wr_ptr_q : ext_t'(wr_addr);
    wr_oob   = wr_valid && ((wr_base + ext_t'(W)) > ext_t'(DEPTH));
    wr_do    = wr_valid && !wr_oob;

    rd_span  = ext_t'(rd_len) * ext_t'(RD_WORDS);
    rd_oob   = (ext_t'(rd_addr) + rd_span) > ext_t'(DEPTH);
    rd_start = (state_q == IDLE) && rd_req && (rd_len != '0) && !rd_oob;
    rd_bad   = (state_q == IDLE) && rd_req && (rd_len != '0) &&  rd_oob;

    rd_fire  = rd_valid_q && rd_ready;
    rd_adv   = (state_q == STREAM) && rd_fire && !rd_last_q;
    rd_done  = (state_q == STREAM) && rd_fire &&  rd_last_q;

    fetch_addr = rd_start ? ext_t'(rd_addr) : (rd_ptr_q + ext_t'(RD_WORDS));
  end

  // ------------------------------------------------------------ FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd_start) state_d = STREAM;
      STREAM:  if (rd_done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_busy = (state_q == STREAM);
  end

  // ------------------------------------------------------------ datapath
  always_comb begin
    mem_d = mem_q;
    if (wr_do) begin
      for (int k = 0; k < W; k++)
        mem_d[ADDR_WIDTH'(wr_base + ext_t'(k))] = wr_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (wr_do && wr_auto) wr_ptr_d = wr_ptr_q + ext_t'(W);
  end

  // Beats are fetched from mem_q, so a store landing on the same edge is
  // not visible to that beat; it shows up from the next fetch on.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    rem_d      = rem_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    rd_data_d  = rd_data_q;
    if (rd_start || rd_adv) begin
      rd_ptr_d   = fetch_addr;
      rd_valid_d = 1'b1;
      for (int i = 0; i < RD_WORDS; i++)
        rd_data_d[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[ADDR_WIDTH'(fetch_addr + ext_t'(i))];
      if (rd_start) begin
        rem_d     = rd_len - LEN_WIDTH'(1);
        rd_last_d = (rd_len == LEN_WIDTH'(1));
      end else begin
        rem_d     = rem_q - LEN_WIDTH'(1);
        rd_last_d = (rem_q == LEN_WIDTH'(1));
      end
    end else if (rd_done) begin
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
    end
  end

  // Set wins over clear when both happen in one cycle.
  always_comb begin
    err_d = err_q;
    if (wr_oob || rd_bad) err_d = 1'b1;
    else if (err_clr)     err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef UB_ACT_PRELOAD_EN
      mem_q[PRELOAD_BASE]     <= DATA_WIDTH'(11);
      mem_q[PRELOAD_BASE + 1] <= DATA_WIDTH'(12);
      mem_q[PRELOAD_BASE + 2] <= DATA_WIDTH'(21);
      mem_q[PRELOAD_BASE + 3] <= DATA_WIDTH'(22);
`endif
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rem_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rem_q      <= rem_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
    end
  end

  // ------------------------------------------------------------ outputs
  assign wr_ready = reset;
  assign wr_ptr   = ADDR_WIDTH'(wr_ptr_q);
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  assign rd_data  = rd_data_q;
  assign err_oob  = err_q;

endmodule

// File: doc/unified_buffer_v2.md
Name: unified_buffer_v2

Overview:
Parametrised unified buffer between the accumulators and the input setup stage. Accepts NUM_CH×CH_WORDS accumulator words per store, at an explicit or auto-incremented address. Streams multi-beat reads of RD_WORDS words per beat to input setup over a valid/ready handshake. Flags out-of-range accesses in a sticky error bit.

Parameters:
DATA_WIDTH, 32, bits per memory word
DEPTH, 64, number of words
ADDR_WIDTH, 6, address width; must satisfy 2^ADDR_WIDTH >= DEPTH
NUM_CH, 2, accumulator channels per store
CH_WORDS, 2, words per channel; W = NUM_CH*CH_WORDS words written per store
RD_WORDS, 4, words per read beat
LEN_WIDTH, 4, width of the read beat-count field
PRELOAD_BASE, 30, first preload address (used only with UB_ACT_PRELOAD_EN)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
wr_valid  input  1  store request
wr_ready  output  1  store can be accepted
wr_auto  input  1  1 = use internal wr_ptr as the store address; 0 = use wr_addr
wr_addr  input  ADDR_WIDTH  explicit store base address
wr_data  input  W*DATA_WIDTH  channel c word j at slice (c*CH_WORDS+j)*DATA_WIDTH
wr_ptr  output  ADDR_WIDTH  next auto-store address
rd_req  input  1  read request pulse
rd_addr  input  ADDR_WIDTH  read base address
rd_len  input  LEN_WIDTH  number of beats
rd_busy  output  1  read in progress
rd_valid  output  1  rd_data valid
rd_ready  input  1  consumer accepts the beat
rd_data  output  RD_WORDS*DATA_WIDTH  word i at slice i*DATA_WIDTH
rd_last  output  1  final beat
err_oob  output  1  sticky out-of-range error
err_clr  input  1  clears err_oob

Behaviour:
- Reset (reset=0, asynchronous): all memory words = 0; wr_ptr=0; rd_valid=0; rd_last=0; rd_busy=0; rd_data=0; err_oob=0; FSM=IDLE. A read in flight is aborted with no further beats.
- wr_ready = 1 whenever reset is deasserted. A store is accepted on a cycle with wr_valid=1.
- Store base is wr_ptr if wr_auto=1, otherwise wr_addr. Word k of wr_data is written to base+k, for k=0..W-1, on the accepting edge.
- If base+W > DEPTH: nothing is written, err_oob sets, and wr_ptr is unchanged. There is no wrap-around.
- wr_ptr advances by W only on an accepted, in-range auto store. Explicit stores never change wr_ptr.
- Read FSM, states IDLE and STREAM:
  - IDLE: rd_req=1 with rd_len>=1 and rd_addr+rd_len*RD_WORDS <= DEPTH latches the base and count and moves to STREAM.
  - IDLE: a rd_req with rd_len=0 is ignored.
  - IDLE: an out-of-range rd_req sets err_oob and stays in IDLE.
- STREAM: the first beat is presented on the edge after rd_req (1-cycle latency). Beat b has rd_data word i = mem[base+b*RD_WORDS+i].
- rd_valid stays high and rd_data is held stable until rd_valid&rd_ready. The next beat appears on the following edge with no bubble.
- rd_last=1 exactly on beat rd_len-1. Its acceptance returns the FSM to IDLE and clears rd_valid, rd_last and rd_busy.
- rd_busy=1 in STREAM. rd_req is ignored while busy.
- Store and read-beat fetch in the same cycle to an overlapping address: the beat fetched on that edge carries the pre-store contents. Beats fetched on later edges see the new data.
- err_oob: set-dominant over err_clr when both occur in the same cycle; otherwise err_clr=1 clears it on the next edge.
- All arithmetic is in ADDR_WIDTH+LEN_WIDTH+1 bits so that range checks cannot overflow.

Optional Feature:
UB_ACT_PRELOAD_EN
- Defined: reset loads activations 11, 12, 21, 22 at PRELOAD_BASE..PRELOAD_BASE+3; all other words are 0. PRELOAD_BASE+3 < DEPTH is required.
- Undefined: reset clears every word to 0 and there is no preload logic.

Test Plan:
- Reset, then 3 auto stores with wr_data words {1..4}, {5..8}, {9..12} -> mem[0..11]=1..12 and wr_ptr=12; then rd_req addr=0 len=3 with rd_ready=1 -> beats {1,2,3,4}, {5,6,7,8}, {9,10,11,12} on 3 consecutive cycles, first beat 1 cycle after the request, rd_last on the third.
- Explicit store wr_addr=60 with data {7,7,7,7} -> mem[60..63]=7, wr_ptr unchanged; wr_addr=61 -> no write, err_oob=1; err_clr -> err_oob=0.
- rd_addr=56, rd_len=3 -> rejected, err_oob=1, rd_busy stays 0; rd_len=0 -> ignored with no error.
- Backpressure: read len=2 with rd_ready=0 for 3 cycles -> beat 0 held stable with rd_valid=1; a second rd_req during this time is ignored; raising rd_ready completes both beats.
- Same cycle: auto store to 0..3 with {9,9,9,9} and a beat fetch of addr 0 -> beat shows the old values; a re-read shows 9s. Reset asserted mid-stream -> rd_valid drops immediately and the memory is cleared.
- With UB_ACT_PRELOAD_EN: after reset, read addr=30 len=1 -> {11,12,21,22}. Without it -> {0,0,0,0}.
